// File: rtl/car_sprite_arbiter_if.sv
// rtl/car_sprite_arbiter_if.sv - request, ROM and response signals of the car sprite arbiter
interface car_sprite_arbiter_if #(
    parameter int DATA_W = 12
);
    logic              req0_valid;
    logic              req0_ready;
    logic [8:0]        req0_degree;
    logic [9:0]        req0_x;
    logic [9:0]        req0_y;
    logic              req1_valid;
    logic              req1_ready;
    logic [8:0]        req1_degree;
    logic [9:0]        req1_x;
    logic [9:0]        req1_y;
    logic              rom_en;
    logic [16:0]       rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_pixel;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_pixel;

    modport slave (
        input  req0_valid, req0_degree, req0_x, req0_y,
        input  req1_valid, req1_degree, req1_x, req1_y,
        output req0_ready, req1_ready,
        output rom_en, rom_addr,
        input  rom_data,
        output rsp0_valid, rsp0_pixel, rsp1_valid, rsp1_pixel
    );

    modport master (
        output req0_valid, req0_degree, req0_x, req0_y,
        output req1_valid, req1_degree, req1_x, req1_y,
        input  req0_ready, req1_ready,
        input  rom_en, rom_addr,
        output rom_data,
        input  rsp0_valid, rsp0_pixel, rsp1_valid, rsp1_pixel
    );
endinterface

// File: rtl/car_sprite_arbiter.sv
// rtl/car_sprite_arbiter.sv - round-robin sharing of the car sprite ROM between two renderers
module car_sprite_arbiter #(
    parameter int                DATA_W      = 12,
    parameter int                ROM_LAT     = 1,
    parameter logic [DATA_W-1:0] TRANSPARENT = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    car_sprite_arbiter_if.slave bus
);
    localparam int DEPTH = 1 + ROM_LAT;
    // Upper-exclusive heading thresholds, frame 0 in the low 9 bits.
    localparam logic [134:0] THR = {
        9'd338, 9'd315, 9'd293, 9'd270, 9'd248, 9'd225, 9'd203, 9'd180,
        9'd158, 9'd135, 9'd113, 9'd90,  9'd68,  9'd45,  9'd23
    };

    logic              last_grant_q, last_grant_d;
    logic              rom_en_q, rom_en_d;
    logic [16:0]       rom_addr_q, rom_addr_d;
    logic [DEPTH-1:0]  pv_q, pv_d;
    logic [DEPTH-1:0]  pid_q, pid_d;
    logic [DEPTH-1:0]  poor_q, poor_d;
    logic [DATA_W-1:0] pix0_q, pix0_d;
    logic [DATA_W-1:0] pix1_q, pix1_d;

    logic              gnt0, gnt1, gnt_any;
    logic [8:0]        sel_deg;
    logic [9:0]        sel_x, sel_y;
    logic [3:0]        idx;
    logic [19:0]       y20, f20, addr_full;
    logic              oor;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp_pix;

    always_comb begin
        gnt0    = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        gnt1    = bus.req1_valid & ~gnt0;
        gnt_any = gnt0 | gnt1;
        sel_deg = gnt1 ? bus.req1_degree : bus.req0_degree;
        sel_x   = gnt1 ? bus.req1_x : bus.req0_x;
        sel_y   = gnt1 ? bus.req1_y : bus.req0_y;

        idx = 4'd15;
        for (int i = 14; i >= 0; i--) begin
            if (sel_deg < THR[i*9 +: 9]) idx = 4'(i);
        end

        // y*600 = y*(512+64+16+8), frame column*75 = f*(64+8+2+1)
        y20 = {10'd0, sel_y};
        f20 = {17'd0, idx[2:0]};
        addr_full = (idx[3] ? 20'd45000 : 20'd0)
                  + (y20 << 9) + (y20 << 6) + (y20 << 4) + (y20 << 3)
                  + (f20 << 6) + (f20 << 3) + (f20 << 1) + f20
                  + {10'd0, sel_x};
        // Bits above 16 can only be set by coordinates that are already out of range.
        oor = (sel_x > 10'd74) | (sel_y > 10'd74) | (|addr_full[19:17]);

        last_grant_d = gnt_any ? gnt1 : last_grant_q;
        rom_en_d     = gnt_any & ~oor;
        rom_addr_d   = rom_en_d ? addr_full[16:0] : rom_addr_q;
        pv_d         = {pv_q[DEPTH-2:0], gnt_any};
        pid_d        = {pid_q[DEPTH-2:0], gnt1};
        poor_d       = {poor_q[DEPTH-2:0], oor};

        rsp0_valid = pv_q[DEPTH-1] & ~pid_q[DEPTH-1];
        rsp1_valid = pv_q[DEPTH-1] &  pid_q[DEPTH-1];
        rsp_pix    = poor_q[DEPTH-1] ? TRANSPARENT : bus.rom_data;
        pix0_d     = rsp0_valid ? rsp_pix : pix0_q;
        pix1_d     = rsp1_valid ? rsp_pix : pix1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            pv_q         <= '0;
            pid_q        <= '0;
            poor_q       <= '0;
            pix0_q       <= '0;
            pix1_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
            pv_q         <= pv_d;
            pid_q        <= pid_d;
            poor_q       <= poor_d;
            pix0_q       <= pix0_d;
            pix1_q       <= pix1_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rom_en     = rom_en_q;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp0_pixel = pix0_d;
    assign bus.rsp1_pixel = pix1_d;
endmodule

// File: tb/tb_car_sprite_arbiter.sv
// tb/tb_car_sprite_arbiter.sv - randomized and directed bench for car_sprite_arbiter
module tb_car_sprite_arbiter;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;

    car_sprite_arbiter_if #(.DATA_W(12)) ifa();
    car_sprite_arbiter_if #(.DATA_W(12)) ifb();

    car_sprite_arbiter #(.DATA_W(12), .ROM_LAT(1), .TRANSPARENT(12'h000)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    car_sprite_arbiter #(.DATA_W(12), .ROM_LAT(3), .TRANSPARENT(12'h000)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] hpix(input logic [16:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd5 + (32'(a) >> 6);
        return t[11:0] ^ 12'h5a5;
    endfunction

    function automatic int ref_addr(input int deg, input int x, input int y);
        int thr[15] = '{23, 45, 68, 90, 113, 135, 158, 180, 203, 225, 248, 270, 293, 315, 338};
        int idx;
        idx = 15;
        for (int i = 0; i < 15; i++) begin
            if (deg < thr[i]) begin
                idx = i;
                break;
            end
        end
        return ((idx >= 8) ? 45000 : 0) + y * 600 + (idx % 8) * 75 + x;
    endfunction

    // ROM models: the LAT=1 ROM registers on the enable edge, the LAT=3 one adds two stages.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ifa.rom_data <= 12'h000;
        else if (ifa.rom_en) ifa.rom_data <= hpix(ifa.rom_addr);
    end

    logic        be1, be2;
    logic [16:0] ba1, ba2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            be1 <= 1'b0; be2 <= 1'b0; ba1 <= '0; ba2 <= '0;
            ifb.rom_data <= 12'h000;
        end else begin
            be1 <= ifb.rom_en; ba1 <= ifb.rom_addr;
            be2 <= be1;        ba2 <= ba1;
            if (be2) ifb.rom_data <= hpix(ba2);
        end
    end

    typedef struct { int due; bit port; logic [11:0] pix; } rsp_t;
    typedef struct { int due; bit oor; logic [16:0] addr; } rom_t;
    rsp_t        rsp_q[$];
    rom_t        rom_q[$];
    bit          lg;
    logic [11:0] held0, held1;
    logic [16:0] exp_addr;

    // Reference model of instance A: arbitration, address, ROM enable and response stream.
    always @(negedge clk) begin
        bit eg0, eg1, ev0, ev1, exp_en, o;
        int a;
        rsp_t r;
        rom_t m;
        if (!rst_n) begin
            lg = 1'b1; held0 = '0; held1 = '0; exp_addr = '0;
            rsp_q.delete(); rom_q.delete();
            n_checks++;
            if ({ifa.rom_en, ifa.rom_addr, ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_pixel, ifa.rsp1_pixel} !== '0)
                $display("FAIL reset_outputs en=%0b addr=%0d v0=%0b v1=%0b p0=%h p1=%h expected all 0",
                         ifa.rom_en, ifa.rom_addr, ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_pixel, ifa.rsp1_pixel);
            else n_pass++;
        end else begin
            eg0 = ifa.req0_valid && (!ifa.req1_valid || lg);
            eg1 = ifa.req1_valid && !eg0;
            n_checks++;
            if ({ifa.req0_ready, ifa.req1_ready} !== {eg0, eg1})
                $display("FAIL ready cyc=%0d got %b%b expected %b%b", cyc, ifa.req0_ready, ifa.req1_ready, eg0, eg1);
            else n_pass++;

            exp_en = 1'b0;
            if (rom_q.size() > 0 && rom_q[0].due == cyc) begin
                m = rom_q.pop_front();
                exp_en = !m.oor;
                if (!m.oor) exp_addr = m.addr;
            end
            n_checks++;
            if ({ifa.rom_en, ifa.rom_addr} !== {exp_en, exp_addr})
                $display("FAIL rom cyc=%0d got en=%0b addr=%0d expected en=%0b addr=%0d",
                         cyc, ifa.rom_en, ifa.rom_addr, exp_en, exp_addr);
            else n_pass++;

            ev0 = 1'b0; ev1 = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                r = rsp_q.pop_front();
                if (r.port) begin ev1 = 1'b1; held1 = r.pix; end
                else begin ev0 = 1'b1; held0 = r.pix; end
            end
            n_checks++;
            if ({ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_pixel, ifa.rsp1_pixel} !== {ev0, ev1, held0, held1})
                $display("FAIL rsp cyc=%0d got v=%b%b p0=%h p1=%h expected v=%b%b p0=%h p1=%h", cyc,
                         ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_pixel, ifa.rsp1_pixel, ev0, ev1, held0, held1);
            else n_pass++;

            if (eg0 || eg1) begin
                if (eg1) begin
                    a = ref_addr(int'(ifa.req1_degree), int'(ifa.req1_x), int'(ifa.req1_y));
                    o = (ifa.req1_x > 74) || (ifa.req1_y > 74);
                end else begin
                    a = ref_addr(int'(ifa.req0_degree), int'(ifa.req0_x), int'(ifa.req0_y));
                    o = (ifa.req0_x > 74) || (ifa.req0_y > 74);
                end
                rom_q.push_back('{due: cyc + 1, oor: o, addr: 17'(a)});
                rsp_q.push_back('{due: cyc + 2, port: eg1, pix: o ? 12'h000 : hpix(17'(a))});
                lg = eg1;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic rand_fields(input bit port);
        if (port) begin
            ifa.req1_degree = 9'($urandom_range(0, 359));
            ifa.req1_x = 10'($urandom_range(0, 74));
            ifa.req1_y = 10'($urandom_range(0, 74));
        end else begin
            ifa.req0_degree = 9'($urandom_range(0, 359));
            ifa.req0_x = 10'($urandom_range(0, 74));
            ifa.req0_y = 10'($urandom_range(0, 74));
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ifa.req0_ready, ifa.req1_ready, ifa.rom_en, ifa.rsp0_valid, ifa.rsp1_valid} !== 5'b0)
            $display("FAIL test_reset got ready=%b%b en=%b v=%b%b expected 0", ifa.req0_ready,
                     ifa.req1_ready, ifa.rom_en, ifa.rsp0_valid, ifa.rsp1_valid);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin
                ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
                if (k == 0) begin rand_fields(0); rand_fields(1); end
                else rand_fields(k[0] ? 1'b0 : 1'b1);
            end else begin
                ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 4) begin
                n_checks++;
                if ({ifa.req0_ready, ifa.req1_ready} !== (k[0] ? 2'b01 : 2'b10))
                    $display("FAIL tie_grant k=%0d got %b%b expected port %0d", k, ifa.req0_ready, ifa.req1_ready, k % 2);
                else n_pass++;
            end
            if (k >= 2) begin
                n_checks++;
                if ({ifa.rsp0_valid, ifa.rsp1_valid} !== (k[0] ? 2'b01 : 2'b10))
                    $display("FAIL tie_rsp k=%0d got %b%b expected port %0d", k, ifa.rsp0_valid, ifa.rsp1_valid, k % 2);
                else n_pass++;
            end
        end
        idle(2);
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        ifa.req0_valid = 1'b1; ifa.req0_degree = 9'd0; ifa.req0_x = 10'd0; ifa.req0_y = 10'd0;
        @(negedge clk);
        n_checks++;
        if (ifa.req0_ready !== 1'b1) $display("FAIL single_ready got %b expected 1", ifa.req0_ready);
        else n_pass++;
        @(posedge clk); #1;
        ifa.req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ifa.rom_en, ifa.rom_addr} !== {1'b1, 17'd0})
            $display("FAIL single_rom got en=%b addr=%0d expected en=1 addr=0", ifa.rom_en, ifa.rom_addr);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ifa.rsp0_valid, ifa.rsp0_pixel} !== {1'b1, hpix(17'd0)})
            $display("FAIL single_rsp got v=%b pix=%h expected v=1 pix=%h", ifa.rsp0_valid, ifa.rsp0_pixel, hpix(17'd0));
        else n_pass++;
        idle(2);
    endtask

    task automatic test_address;
        int deg[5] = '{200, 100, 359, 22, 23};
        int xs[5]  = '{10, 74, 74, 0, 0};
        int ys[5]  = '{2, 74, 74, 0, 0};
        int ex[5]  = '{46210, 44774, 89999, 0, 75};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ifa.req0_valid = 1'b1;
            ifa.req0_degree = 9'(deg[i]); ifa.req0_x = 10'(xs[i]); ifa.req0_y = 10'(ys[i]);
            @(negedge clk);
            @(posedge clk); #1;
            ifa.req0_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({ifa.rom_en, ifa.rom_addr} !== {1'b1, 17'(ex[i])})
                $display("FAIL address deg=%0d x=%0d y=%0d got en=%b addr=%0d expected %0d",
                         deg[i], xs[i], ys[i], ifa.rom_en, ifa.rom_addr, ex[i]);
            else n_pass++;
        end
        idle(2);
    endtask

    task automatic test_oor;
        @(posedge clk); #1;
        ifa.req1_valid = 1'b1; ifa.req1_degree = 9'd40; ifa.req1_x = 10'd75; ifa.req1_y = 10'd0;
        @(negedge clk);
        n_checks++;
        if (ifa.req1_ready !== 1'b1) $display("FAIL oor_ready got %b expected 1", ifa.req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        ifa.req1_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ifa.rom_en !== 1'b0) $display("FAIL oor_rom_en got %b expected 0", ifa.rom_en);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ifa.rsp1_valid, ifa.rsp1_pixel} !== {1'b1, 12'h000})
            $display("FAIL oor_rsp got v=%b pix=%h expected v=1 pix=000", ifa.rsp1_valid, ifa.rsp1_pixel);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_random;
        bit r0, r1;
        r0 = 1'b1; r1 = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (!ifa.req0_valid || r0) begin
                ifa.req0_valid = 1'($urandom_range(0, 1));
                ifa.req0_degree = 9'($urandom_range(0, 511));
                ifa.req0_x = 10'($urandom_range(0, 80));
                ifa.req0_y = 10'($urandom_range(0, 80));
            end
            if (!ifa.req1_valid || r1) begin
                ifa.req1_valid = 1'($urandom_range(0, 1));
                ifa.req1_degree = 9'($urandom_range(0, 511));
                ifa.req1_x = 10'($urandom_range(0, 80));
                ifa.req1_y = 10'($urandom_range(0, 80));
            end
            @(negedge clk);
            r0 = ifa.req0_ready; r1 = ifa.req1_ready;
            n_checks++;
            if (ifa.rsp0_valid && ifa.rsp1_valid)
                $display("FAIL rsp_exclusive cyc=%0d got both valid expected at most one", cyc);
            else n_pass++;
        end
        idle(3);
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
            rand_fields(0); rand_fields(1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        ifa.req0_valid = 1'b0; ifa.req1_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ifa.rsp0_valid, ifa.rsp1_valid, ifa.rom_en, ifa.rsp0_pixel, ifa.rsp1_pixel} !== '0)
            $display("FAIL reset_mid_outputs got v=%b%b en=%b p0=%h p1=%h expected 0",
                     ifa.rsp0_valid, ifa.rsp1_valid, ifa.rom_en, ifa.rsp0_pixel, ifa.rsp1_pixel);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ifa.rsp0_valid, ifa.rsp1_valid} !== 2'b00)
                $display("FAIL reset_mid_flush k=%0d got v=%b%b expected 00", k, ifa.rsp0_valid, ifa.rsp1_valid);
            else n_pass++;
            @(posedge clk); #1;
        end
        ifa.req0_valid = 1'b1; ifa.req1_valid = 1'b1;
        rand_fields(0); rand_fields(1);
        @(negedge clk);
        n_checks++;
        if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10)
            $display("FAIL reset_mid_tie got %b%b expected 10", ifa.req0_ready, ifa.req1_ready);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_lat3;
        logic [11:0] ex[5];
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k < 5) begin
                ifb.req0_valid = 1'b1;
                ifb.req0_degree = 9'($urandom_range(0, 359));
                ifb.req0_x = 10'($urandom_range(0, 74));
                ifb.req0_y = 10'($urandom_range(0, 74));
                ex[k] = hpix(17'(ref_addr(int'(ifb.req0_degree), int'(ifb.req0_x), int'(ifb.req0_y))));
            end else begin
                ifb.req0_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 5) begin
                n_checks++;
                if (ifb.req0_ready !== 1'b1) $display("FAIL lat3_ready k=%0d got %b expected 1", k, ifb.req0_ready);
                else n_pass++;
            end
            n_checks++;
            if (k >= 4 && k <= 8) begin
                if ({ifb.rsp0_valid, ifb.rsp1_valid, ifb.rsp0_pixel} !== {2'b10, ex[k-4]})
                    $display("FAIL lat3_rsp k=%0d got v=%b%b pix=%h expected v=10 pix=%h",
                             k, ifb.rsp0_valid, ifb.rsp1_valid, ifb.rsp0_pixel, ex[k-4]);
                else n_pass++;
            end else begin
                if ({ifb.rsp0_valid, ifb.rsp1_valid} !== 2'b00)
                    $display("FAIL lat3_idle k=%0d got v=%b%b expected 00", k, ifb.rsp0_valid, ifb.rsp1_valid);
                else n_pass++;
            end
        end
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_pass = 0;
        rst_n = 1'b0;
        ifa.req0_valid = 1'b0; ifa.req0_degree = '0; ifa.req0_x = '0; ifa.req0_y = '0;
        ifa.req1_valid = 1'b0; ifa.req1_degree = '0; ifa.req1_x = '0; ifa.req1_y = '0;
        ifb.req0_valid = 1'b0; ifb.req0_degree = '0; ifb.req0_x = '0; ifb.req0_y = '0;
        ifb.req1_valid = 1'b0; ifb.req1_degree = '0; ifb.req1_x = '0; ifb.req1_y = '0;
        test_reset();
        test_tie();
        test_single();
        test_address();
        test_oor();
        test_random();
        test_reset_mid();
        test_lat3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
